// File: rtl/alarm_pkg.sv
// Shared types and time constants for the alarm controller and its snooze adder.
// The snooze path in the users of this package is enabled by ALARM_SNOOZE_EN.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } alarm_state_t;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } hms_t;

  localparam int SEC_PER_MIN = 60;
  localparam int MIN_PER_HR  = 60;
  localparam int HR_PER_DAY  = 24;

endpackage

// File: rtl/alarm_time_adder.sv
// Combinational hh:mm:ss + ADD_MIN minutes with hour carry and midnight wrap.
// Only compiled when ALARM_SNOOZE_EN is defined, since only the snooze path uses it.
`ifdef ALARM_SNOOZE_EN
module alarm_time_adder
  import alarm_pkg::*;
#(
  parameter int ADD_MIN = 9
) (
  input  hms_t i_time,
  output hms_t o_time
);

  logic [6:0] w_min_sum;
  logic       w_carry;
  logic [4:0] w_hr_inc;

  assign w_min_sum = {1'b0, i_time.minutes} + 7'(ADD_MIN);
  assign w_carry   = (w_min_sum >= 7'(MIN_PER_HR));
  assign w_hr_inc  = i_time.hours + 5'd1;

  // Adding at most 59 minutes can carry at most one hour, so one subtract suffices.
  always_comb begin
    o_time.seconds = i_time.seconds;
    o_time.minutes = w_carry ? 6'(w_min_sum - 7'(MIN_PER_HR)) : w_min_sum[5:0];
    if (!w_carry)
      o_time.hours = i_time.hours;
    else if (w_hr_inc == 5'(HR_PER_DAY))
      o_time.hours = 5'd0;
    else
      o_time.hours = w_hr_inc;
  end

endmodule
`endif

// File: rtl/alarm_controller.sv
// Alarm sequencer: arm/ring/snooze/stop FSM, rising-edge match trigger, ring timeout.
// Define ALARM_SNOOZE_EN to build the snooze path; without it snooze is ignored.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 9,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_tick_1hz,
  input  logic                            i_alarm_en,
  input  logic [5:0]                      i_seconds,
  input  logic [5:0]                      i_minutes,
  input  logic [4:0]                      i_hours,
  input  logic [5:0]                      i_alarm_seconds,
  input  logic [5:0]                      i_alarm_minutes,
  input  logic [4:0]                      i_alarm_hours,
  input  logic                            i_snooze_btn,
  input  logic                            i_stop_btn,
  output logic                            o_buzzer,
  output logic                            o_snooze_active,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] o_snooze_count,
  output logic [5:0]                      o_target_seconds,
  output logic [5:0]                      o_target_minutes,
  output logic [4:0]                      o_target_hours
);

  localparam int CNT_W  = $clog2(MAX_SNOOZE + 1);
  localparam int RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ARMED   = ST_ARMED;
  localparam logic [1:0] S_RINGING = ST_RINGING;
  localparam logic [1:0] S_SNOOZED = ST_SNOOZED;

  hms_t              w_now;
  hms_t              w_prog;
  hms_t              w_snooze_tgt;
  hms_t              r_target;
  hms_t              w_target_nxt;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_snooze_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [RING_W-1:0] r_ring_cnt;
  logic [RING_W-1:0] w_ring_nxt;
  logic              r_match_d;
  logic              r_buzzer;
  logic              r_snooze_act;
  logic              w_match;
  logic              w_trigger;
  logic              w_timeout;
  logic              w_snooze_ok;

  assign w_now     = {i_hours, i_minutes, i_seconds};
  assign w_prog    = {i_alarm_hours, i_alarm_minutes, i_alarm_seconds};
  assign w_match   = (w_now == r_target);
  assign w_trigger = w_match && !r_match_d;
  assign w_timeout = i_tick_1hz && (r_ring_cnt == RING_W'(RING_SEC - 1));

`ifdef ALARM_SNOOZE_EN
  alarm_time_adder #(
    .ADD_MIN (SNOOZE_MIN)
  ) u_snooze_add (
    .i_time (w_now),
    .o_time (w_snooze_tgt)
  );

  assign w_snooze_ok = i_snooze_btn && (r_snooze_cnt < CNT_W'(MAX_SNOOZE));
`else
  logic w_unused_snooze;

  assign w_snooze_tgt    = w_prog;
  assign w_snooze_ok     = 1'b0;
  assign w_unused_snooze = i_snooze_btn | (SNOOZE_MIN == 0);
`endif

  // Next-state logic; alarm_en low overrides everything and parks the FSM in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_snooze_cnt;
    w_ring_nxt   = r_ring_cnt;
    if (!i_alarm_en) begin
      w_state_nxt  = S_IDLE;
      w_target_nxt = w_prog;
      w_cnt_nxt    = '0;
      w_ring_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_ARMED;
          w_target_nxt = w_prog;
        end
        S_ARMED: begin
          w_target_nxt = w_prog;
          if (w_trigger) begin
            w_state_nxt = S_RINGING;
            w_ring_nxt  = '0;
          end
        end
        S_RINGING: begin
          if (i_tick_1hz)
            w_ring_nxt = r_ring_cnt + RING_W'(1);
          // Stop beats snooze, and snooze beats the timeout.
          if (i_stop_btn || (!w_snooze_ok && w_timeout)) begin
            w_state_nxt  = S_ARMED;
            w_target_nxt = w_prog;
            w_cnt_nxt    = '0;
            w_ring_nxt   = '0;
          end else if (w_snooze_ok) begin
            w_state_nxt  = S_SNOOZED;
            w_target_nxt = w_snooze_tgt;
            w_cnt_nxt    = r_snooze_cnt + CNT_W'(1);
          end
        end
        S_SNOOZED: begin
          if (i_stop_btn) begin
            w_state_nxt  = S_ARMED;
            w_target_nxt = w_prog;
            w_cnt_nxt    = '0;
            w_ring_nxt   = '0;
          end else if (w_trigger) begin
            w_state_nxt = S_RINGING;
            w_ring_nxt  = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
`ifndef ALARM_SNOOZE_EN
    w_target_nxt = w_prog;
`endif
  end

  // Outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_target     <= '0;
      r_snooze_cnt <= '0;
      r_ring_cnt   <= '0;
      r_match_d    <= 1'b0;
      r_buzzer     <= 1'b0;
      r_snooze_act <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_target     <= w_target_nxt;
      r_snooze_cnt <= w_cnt_nxt;
      r_ring_cnt   <= w_ring_nxt;
      r_match_d    <= w_match;
      r_buzzer     <= (w_state_nxt == S_RINGING);
      r_snooze_act <= (w_state_nxt == S_SNOOZED);
    end
  end

  assign o_buzzer         = r_buzzer;
  assign o_snooze_active  = r_snooze_act;
  assign o_snooze_count   = r_snooze_cnt;
  assign o_target_seconds = r_target.seconds;
  assign o_target_minutes = r_target.minutes;
  assign o_target_hours   = r_target.hours;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller (defaults: SNOOZE_MIN 9, RING_SEC 60, MAX_SNOOZE 3).
// Snooze scenarios are compiled when ALARM_SNOOZE_EN is defined, otherwise snooze-ignored checks run.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rstN;
  logic       tick1hz;
  logic       alarmEn;
  logic [5:0] sec, mins;
  logic [4:0] hrs;
  logic [5:0] almSec, almMin;
  logic [4:0] almHr;
  logic       snoozeBtn, stopBtn;
  logic       buzzer, snoozeActive;
  logic [1:0] snoozeCount;
  logic [5:0] tgtSec, tgtMin;
  logic [4:0] tgtHr;

  int nChecks = 0;
  int nFails  = 0;

  alarm_controller dut (
    .clk              (clk),
    .rst_n            (rstN),
    .i_tick_1hz       (tick1hz),
    .i_alarm_en       (alarmEn),
    .i_seconds        (sec),
    .i_minutes        (mins),
    .i_hours          (hrs),
    .i_alarm_seconds  (almSec),
    .i_alarm_minutes  (almMin),
    .i_alarm_hours    (almHr),
    .i_snooze_btn     (snoozeBtn),
    .i_stop_btn       (stopBtn),
    .o_buzzer         (buzzer),
    .o_snooze_active  (snoozeActive),
    .o_snooze_count   (snoozeCount),
    .o_target_seconds (tgtSec),
    .o_target_minutes (tgtMin),
    .o_target_hours   (tgtHr)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setTime(input int h, input int m, input int s);
    hrs = 5'(h); mins = 6'(m); sec = 6'(s);
  endtask

  task automatic setAlarm(input int h, input int m, input int s);
    almHr = 5'(h); almMin = 6'(m); almSec = 6'(s);
  endtask

  task automatic pulseStop();
    stopBtn = 1'b1; cycle(); stopBtn = 1'b0;
  endtask

  task automatic pulseSnooze();
    snoozeBtn = 1'b1; cycle(); snoozeBtn = 1'b0;
  endtask

  // Program a fresh alarm with time one hour away, then step time onto it.
  task automatic armAndRing(input int h, input int m, input int s);
    setAlarm(h, m, s);
    setTime((h + 1) % 24, m, s);
    cycle(); cycle();
    setTime(h, m, s);
    cycle();
  endtask

  task automatic test_reset();
    rstN = 1'b0; tick1hz = 1'b0; alarmEn = 1'b1; snoozeBtn = 1'b0; stopBtn = 1'b0;
    setTime(6, 59, 59); setAlarm(7, 0, 0);
    cycle(); cycle();
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL reset_buzzer: got %b want 0", buzzer); nFails++; end
    nChecks++;
    if (snoozeActive !== 1'b0) begin $display("[TB] FAIL reset_snooze_active: got %b want 0", snoozeActive); nFails++; end
    nChecks++;
    if (snoozeCount !== 2'd0) begin $display("[TB] FAIL reset_snooze_count: got %0d want 0", snoozeCount); nFails++; end
    nChecks++;
    if ({tgtHr, tgtMin, tgtSec} !== hms(0, 0, 0)) begin
      $display("[TB] FAIL reset_target: got %0d:%0d:%0d want 0:0:0", tgtHr, tgtMin, tgtSec); nFails++;
    end
    rstN = 1'b1;
  endtask

  task automatic test_trigger();
    cycle(); cycle(); cycle();
    nChecks++;
    if ({tgtHr, tgtMin, tgtSec} !== hms(7, 0, 0)) begin
      $display("[TB] FAIL armed_target: got %0d:%0d:%0d want 7:0:0", tgtHr, tgtMin, tgtSec); nFails++;
    end
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL armed_quiet: got %b want 0", buzzer); nFails++; end
    setTime(7, 0, 0); tick1hz = 1'b1;
    cycle();
    tick1hz = 1'b0;
    nChecks++;
    if (buzzer !== 1'b1) begin $display("[TB] FAIL trigger_buzzer: got %b want 1", buzzer); nFails++; end
    pulseStop();
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL stop_buzzer: got %b want 0", buzzer); nFails++; end
    cycle(); cycle(); cycle();
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL held_match_retrigger: got %b want 0", buzzer); nFails++; end
  endtask

  task automatic test_button_on_trigger();
    setTime(7, 0, 1);
    cycle();
    setTime(7, 0, 0); stopBtn = 1'b1;
    cycle();
    stopBtn = 1'b0;
    nChecks++;
    if (buzzer !== 1'b1) begin $display("[TB] FAIL stop_same_cycle_as_trigger: got %b want 1", buzzer); nFails++; end
  endtask

  task automatic test_back_to_back();
    snoozeBtn = 1'b1; stopBtn = 1'b1;
    cycle();
    snoozeBtn = 1'b0; stopBtn = 1'b0;
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL both_btn_buzzer: got %b want 0", buzzer); nFails++; end
    nChecks++;
    if (snoozeActive !== 1'b0) begin $display("[TB] FAIL both_btn_snooze_active: got %b want 0", snoozeActive); nFails++; end
    nChecks++;
    if ({tgtHr, tgtMin, tgtSec} !== hms(7, 0, 0)) begin
      $display("[TB] FAIL both_btn_target: got %0d:%0d:%0d want 7:0:0", tgtHr, tgtMin, tgtSec); nFails++;
    end
  endtask

  task automatic test_timeout();
    armAndRing(8, 0, 0);
    nChecks++;
    if (buzzer !== 1'b1) begin $display("[TB] FAIL timeout_start: got %b want 1", buzzer); nFails++; end
    for (int i = 0; i < 59; i++) begin
      tick1hz = 1'b1; cycle(); tick1hz = 1'b0; cycle();
    end
    nChecks++;
    if (buzzer !== 1'b1) begin $display("[TB] FAIL timeout_after_59: got %b want 1", buzzer); nFails++; end
    tick1hz = 1'b1; cycle(); tick1hz = 1'b0;
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL timeout_after_60: got %b want 0", buzzer); nFails++; end
    nChecks++;
    if (snoozeCount !== 2'd0) begin $display("[TB] FAIL timeout_count: got %0d want 0", snoozeCount); nFails++; end
    cycle(); cycle();
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL timeout_rearm_quiet: got %b want 0", buzzer); nFails++; end
  endtask

  task automatic test_alarm_change();
    setTime(9, 30, 0); setAlarm(9, 29, 0);
    cycle(); cycle();
    setAlarm(9, 30, 0);
    cycle();
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL alarm_change_early: got %b want 0", buzzer); nFails++; end
    cycle();
    nChecks++;
    if (buzzer !== 1'b1) begin $display("[TB] FAIL alarm_change_trigger: got %b want 1", buzzer); nFails++; end
    pulseStop();
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    armAndRing(7, 0, 0);
    pulseSnooze();
    nChecks++;
    if (buzzer !== 1'b0 || snoozeActive !== 1'b1) begin
      $display("[TB] FAIL snooze_state: got buzzer=%b active=%b want 0/1", buzzer, snoozeActive); nFails++;
    end
    nChecks++;
    if (snoozeCount !== 2'd1) begin $display("[TB] FAIL snooze_count: got %0d want 1", snoozeCount); nFails++; end
    nChecks++;
    if ({tgtHr, tgtMin, tgtSec} !== hms(7, 9, 0)) begin
      $display("[TB] FAIL snooze_target: got %0d:%0d:%0d want 7:9:0", tgtHr, tgtMin, tgtSec); nFails++;
    end
    setTime(7, 9, 0);
    cycle();
    nChecks++;
    if (buzzer !== 1'b1) begin $display("[TB] FAIL snooze_rering: got %b want 1", buzzer); nFails++; end
    pulseStop();
  endtask

  task automatic test_snooze_wrap();
    int expM [3] = '{4, 13, 22};
    armAndRing(23, 55, 10);
    for (int k = 0; k < 3; k++) begin
      pulseSnooze();
      nChecks++;
      if ({tgtHr, tgtMin, tgtSec} !== hms(0, expM[k], 10) || snoozeCount !== 2'(k + 1)) begin
        $display("[TB] FAIL snooze_wrap_%0d: got %0d:%0d:%0d n=%0d want 0:%0d:10 n=%0d",
                 k, tgtHr, tgtMin, tgtSec, snoozeCount, expM[k], k + 1);
        nFails++;
      end
      setTime(0, expM[k], 10);
      cycle();
    end
    pulseSnooze();
    nChecks++;
    if (buzzer !== 1'b1 || snoozeCount !== 2'd3) begin
      $display("[TB] FAIL snooze_max_ignored: got buzzer=%b n=%0d want 1/3", buzzer, snoozeCount); nFails++;
    end
    pulseStop();
    armAndRing(5, 10, 0);
    pulseSnooze();
    alarmEn = 1'b0;
    cycle();
    nChecks++;
    if (buzzer !== 1'b0 || snoozeActive !== 1'b0 || snoozeCount !== 2'd0) begin
      $display("[TB] FAIL snoozed_disable: got buzzer=%b active=%b n=%0d want 0/0/0", buzzer, snoozeActive, snoozeCount);
      nFails++;
    end
    alarmEn = 1'b1;
    cycle();
  endtask
`else
  task automatic test_snooze_ignored();
    armAndRing(7, 0, 0);
    pulseSnooze();
    nChecks++;
    if (buzzer !== 1'b1) begin $display("[TB] FAIL snooze_off_buzzer: got %b want 1", buzzer); nFails++; end
    nChecks++;
    if (snoozeActive !== 1'b0 || snoozeCount !== 2'd0) begin
      $display("[TB] FAIL snooze_off_outputs: got active=%b n=%0d want 0/0", snoozeActive, snoozeCount); nFails++;
    end
    nChecks++;
    if ({tgtHr, tgtMin, tgtSec} !== hms(7, 0, 0)) begin
      $display("[TB] FAIL snooze_off_target: got %0d:%0d:%0d want 7:0:0", tgtHr, tgtMin, tgtSec); nFails++;
    end
    pulseStop();
  endtask
`endif

  task automatic test_disable();
    armAndRing(6, 30, 0);
    alarmEn = 1'b0;
    cycle();
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL disable_buzzer: got %b want 0", buzzer); nFails++; end
    nChecks++;
    if ({tgtHr, tgtMin, tgtSec} !== hms(6, 30, 0)) begin
      $display("[TB] FAIL disable_target: got %0d:%0d:%0d want 6:30:0", tgtHr, tgtMin, tgtSec); nFails++;
    end
    alarmEn = 1'b1;
    cycle(); cycle(); cycle();
    nChecks++;
    if (buzzer !== 1'b0) begin $display("[TB] FAIL reenable_no_trigger: got %b want 0", buzzer); nFails++; end
  endtask

  task automatic test_reset_midring();
    armAndRing(5, 0, 0);
    nChecks++;
    if (buzzer !== 1'b1) begin $display("[TB] FAIL midring_start: got %b want 1", buzzer); nFails++; end
    #2;
    rstN = 1'b0;
    #1;
    nChecks++;
    if (buzzer !== 1'b0 || snoozeActive !== 1'b0 || snoozeCount !== 2'd0) begin
      $display("[TB] FAIL async_reset_outputs: got buzzer=%b active=%b n=%0d want 0/0/0", buzzer, snoozeActive, snoozeCount);
      nFails++;
    end
    nChecks++;
    if ({tgtHr, tgtMin, tgtSec} !== hms(0, 0, 0)) begin
      $display("[TB] FAIL async_reset_target: got %0d:%0d:%0d want 0:0:0", tgtHr, tgtMin, tgtSec); nFails++;
    end
    cycle();
    rstN = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_button_on_trigger();
    test_back_to_back();
    test_timeout();
    test_alarm_change();
`ifdef ALARM_SNOOZE_EN
    test_snooze();
    test_snooze_wrap();
`else
    test_snooze_ignored();
`endif
    test_disable();
    test_reset_midring();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequencing controller for the alarm datapath. Compares running time against the effective alarm target, owns the arm/ring/snooze/stop state machine, drives the buzzer, and auto-silences after a ring timeout. Sits between the timekeeping counters, the user buttons and the display/compare stage; its `target_*` outputs feed the display path in alarm mode.

## Interface
- `SNOOZE_MIN`, default 9: minutes added to current time on snooze, 1..59.
- `RING_SEC`, default 60: ticks of ringing before auto-stop, ≥1.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick_1hz`  in  1  one-cycle pulse per second, coincident with time advancing.
- `alarm_en`  in  1  level; alarm function enabled.
- `seconds`, `minutes`  in  6 each  current time.
- `hours`  in  5  current time, 0..23.
- `alarm_seconds`, `alarm_minutes`  in  6 each  programmed alarm.
- `alarm_hours`  in  5  programmed alarm.
- `snooze_btn`, `stop_btn`  in  1 each  debounced one-cycle pulses.
- `buzzer`  out  1  registered; high while RINGING.
- `snooze_active`  out  1  registered; high in SNOOZED.
- `snooze_count`  out  $clog2(MAX_SNOOZE+1)  snoozes used this event.
- `target_seconds`, `target_minutes`  out  6 each  effective compare target.
- `target_hours`  out  5  effective compare target.

## Operation
- States: IDLE, ARMED, RINGING, SNOOZED.
- Match: `time == target`. A trigger is the rising edge of match, using a registered `match_d`. A held match never re-triggers.
- `alarm_en` low in any state → IDLE next cycle. This clears `buzzer`, `snooze_count` and the ring counter, and reloads target from the programmed alarm.
- IDLE → ARMED when `alarm_en` is high.
- ARMED: target tracks the programmed alarm every cycle. On trigger → RINGING, and the ring counter clears.
- RINGING:
  - The ring counter increments on each `tick_1hz`.
  - `stop_btn` → ARMED; `snooze_count` := 0; target := programmed alarm.
  - `snooze_btn` with `snooze_count < MAX_SNOOZE` → SNOOZED; target := current time + `SNOOZE_MIN` minutes; `snooze_count` += 1.
  - `snooze_btn` at `MAX_SNOOZE` is ignored.
  - Ring counter at `RING_SEC-1` together with `tick_1hz` → ARMED, handled the same as a stop.
  - Precedence: `stop_btn` > `snooze_btn` > timeout.
- SNOOZED:
  - Target is frozen.
  - Trigger → RINGING.
  - `stop_btn` → ARMED, with the same effects as a stop.
  - `snooze_btn` is ignored.
- Snooze add arithmetic:
  - Seconds are unchanged.
  - minutes + `SNOOZE_MIN`; if ≥60, subtract 60 and carry 1 hour.
  - If hours reach 24, wrap to 0. Example: 23:55:10 + 9 → 00:04:10.
- Programmed alarm changing to equal current time produces a match edge, which is a legal trigger in ARMED.

## Timing
- Reset values:
  - state IDLE
  - `buzzer` 0, `snooze_active` 0, `snooze_count` 0
  - `match_d` 0, ring counter 0
  - `target_*` 0
- Trigger latency: match edge seen in cycle N → `buzzer` high in N+1.
- Button latency: pulse in cycle N → state and outputs updated in N+1.
- A button pulse arriving in the same cycle as the trigger is ignored, because the state is not yet RINGING.
- Reset mid-ring drops `buzzer` asynchronously.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - Snooze path is present as described.
- `ALARM_SNOOZE_EN` undefined:
  - `snooze_btn` is ignored and SNOOZED is unreachable.
  - `snooze_active` and `snooze_count` are tied 0.
  - Target always equals the programmed alarm.
  - No snooze adder is instantiated.

## Structure
- Package `alarm_pkg` holds:
  - state enum `alarm_state_t`
  - packed struct `hms_t` with {hours[4:0], minutes[5:0], seconds[5:0]}
  - constants `SEC_PER_MIN=60`, `MIN_PER_HR=60`, `HR_PER_DAY=24`
- Sub-module `alarm_time_adder` is purely combinational. It computes `hms_t` + N minutes with wrap, and is instantiated only under `ALARM_SNOOZE_EN`.

## Test plan
- Alarm 07:00:00, time reaches 07:00:00 → `buzzer`=1 next cycle; held match over later cycles causes no re-trigger.
- Ringing at 07:00:00, `snooze_btn` → SNOOZED, target 07:09:00, `snooze_count`=1; at 07:09:00 ring again.
- Alarm 23:55:10, snooze at match → target 00:04:10; fourth snooze with `MAX_SNOOZE`=3 ignored, still RINGING.
- Ringing, no buttons, `RING_SEC`=60 → `buzzer` drops the cycle after the 60th tick; state ARMED, `snooze_count`=0.
- `snooze_btn` and `stop_btn` in the same cycle while RINGING → ARMED, target = programmed alarm.
- `alarm_en` deasserted while SNOOZED → IDLE; `buzzer`=0; `snooze_count`=0; `rst_n` low mid-ring → all outputs 0 immediately.
